// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL configuration controller: register map,
// parameter reset values and acquisition FSM encoding.
package adpll_pkg;

  localparam int unsigned NUM_REGS = 8;

  localparam logic [2:0] SEL_KP_ACQ   = 3'd0;
  localparam logic [2:0] SEL_KI_ACQ   = 3'd1;
  localparam logic [2:0] SEL_KP_TRK   = 3'd2;
  localparam logic [2:0] SEL_KI_TRK   = 3'd3;
  localparam logic [2:0] SEL_DIV_N    = 3'd4;
  localparam logic [2:0] SEL_DCO_INIT = 3'd5;
  localparam logic [2:0] SEL_LOCK_WIN = 3'd6;
  localparam logic [2:0] SEL_LOCK_CNT = 3'd7;

  localparam int unsigned RST_KP_ACQ   = 8;
  localparam int unsigned RST_KI_ACQ   = 4;
  localparam int unsigned RST_KP_TRK   = 4;
  localparam int unsigned RST_KI_TRK   = 1;
  localparam int unsigned RST_DIV_N    = 16;
  localparam int unsigned RST_DCO_INIT = 16;
  localparam int unsigned RST_LOCK_WIN = 2;
  localparam int unsigned RST_LOCK_CNT = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  function automatic int unsigned reset_value(input logic [2:0] sel);
    case (sel)
      SEL_KP_ACQ:   reset_value = RST_KP_ACQ;
      SEL_KI_ACQ:   reset_value = RST_KI_ACQ;
      SEL_KP_TRK:   reset_value = RST_KP_TRK;
      SEL_KI_TRK:   reset_value = RST_KI_TRK;
      SEL_DIV_N:    reset_value = RST_DIV_N;
      SEL_DCO_INIT: reset_value = RST_DCO_INIT;
      SEL_LOCK_WIN: reset_value = RST_LOCK_WIN;
      default:      reset_value = RST_LOCK_CNT;
    endcase
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with registered level and
// registered rising-edge pulse outputs (both aligned to the same cycle).
module pin_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
      // level doubles as the previous-sample register for edge detection
      level <= sync[STAGES-1];
      rise  <= sync[STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/adpll_cfg_ctrl.sv
// ADPLL configuration register bank and LOAD/ACQ/TRACK gear-shift controller
// driving PI gains, divider/DCO presets, loop_rst and lock indication.
module adpll_cfg_ctrl
  import adpll_pkg::*;
#(
  parameter int unsigned W           = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOAD_CYCLES = 4,
  parameter int unsigned UNLOCK_CNT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pgm,
  input  logic         clr,
  input  logic [2:0]   param_sel,
  input  logic [W-1:0] pgm_value,
  input  logic         upd_tick,
  input  logic [W-1:0] err_mag,
  output logic [W-1:0] kp,
  output logic [W-1:0] ki,
  output logic [W-1:0] div_n,
  output logic [W-1:0] dco_init,
  output logic         loop_rst,
  output logic         gear,
  output logic         locked
);

  localparam int unsigned LDW     = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LDW-1:0] LD_LAST = LDW'(LOAD_CYCLES - 1);
  localparam logic [W-1:0]   UNLK    = W'(UNLOCK_CNT);

  logic pgm_lvl, pgm_rise, clr_lvl, clr_rise;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_pgm_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pgm),
    .level (pgm_lvl),
    .rise  (pgm_rise)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_clr_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (clr),
    .level (clr_lvl),
    .rise  (clr_rise)
  );

  logic clear, wr_en, force_load;
  assign clear      = clr_lvl | clr_rise;
  assign wr_en      = pgm_rise & pgm_lvl & ~clear;
  assign force_load = clear |
                      (wr_en & ((param_sel == SEL_DIV_N) || (param_sel == SEL_DCO_INIT)));

  // Register bank; entries 0-3 are the gain shadows.
  logic [W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= W'(reset_value(3'(i)));
    end else if (wr_en) begin
      regs[param_sel] <= pgm_value;
    end
  end

  assign div_n    = regs[SEL_DIV_N];
  assign dco_init = regs[SEL_DCO_INIT];

  logic [W-1:0] kp_acq, ki_acq, kp_trk, ki_trk;
  logic [W-1:0] kp_acq_d, ki_acq_d, kp_trk_d, ki_trk_d;

  always_comb begin
    kp_acq_d = kp_acq;
    ki_acq_d = ki_acq;
    kp_trk_d = kp_trk;
    ki_trk_d = ki_trk;
    if (clear) begin
      kp_acq_d = W'(RST_KP_ACQ);
      ki_acq_d = W'(RST_KI_ACQ);
      kp_trk_d = W'(RST_KP_TRK);
      ki_trk_d = W'(RST_KI_TRK);
    end else if (upd_tick) begin
      kp_acq_d = regs[SEL_KP_ACQ];
      ki_acq_d = regs[SEL_KI_ACQ];
      kp_trk_d = regs[SEL_KP_TRK];
      ki_trk_d = regs[SEL_KI_TRK];
    end
  end

  state_t         state, state_d;
  logic [LDW-1:0] ld_cnt, ld_cnt_d;
  logic [W-1:0]   lk_cnt, lk_cnt_d, lk_inc, lock_target;
  logic           in_win;
  logic           loop_rst_d, track_d;
  logic [W-1:0]   kp_d, ki_d;

  assign in_win      = (err_mag <= regs[SEL_LOCK_WIN]);
  assign lock_target = (regs[SEL_LOCK_CNT] == '0) ? W'(1) : regs[SEL_LOCK_CNT];
  assign lk_inc      = (lk_cnt == '1) ? lk_cnt : lk_cnt + 1'b1;

  // lk_cnt counts in-window ticks in ACQ and out-of-window ticks in TRACK.
  always_comb begin
    state_d  = state;
    ld_cnt_d = ld_cnt;
    lk_cnt_d = lk_cnt;
    if (force_load) begin
      state_d  = ST_LOAD;
      ld_cnt_d = '0;
      lk_cnt_d = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          lk_cnt_d = '0;
          if (ld_cnt >= LD_LAST) begin
            state_d  = ST_ACQ;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt + 1'b1;
          end
        end
        ST_ACQ: begin
          if (upd_tick) begin
            if (!in_win) begin
              lk_cnt_d = '0;
            end else if (lk_inc >= lock_target) begin
              state_d  = ST_TRACK;
              lk_cnt_d = '0;
            end else begin
              lk_cnt_d = lk_inc;
            end
          end
        end
        ST_TRACK: begin
          if (upd_tick) begin
            if (in_win) begin
              lk_cnt_d = '0;
            end else if (lk_inc >= UNLK) begin
              state_d  = ST_ACQ;
              lk_cnt_d = '0;
            end else begin
              lk_cnt_d = lk_inc;
            end
          end
        end
        default: begin
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
          lk_cnt_d = '0;
        end
      endcase
    end
    loop_rst_d = (state_d == ST_LOAD);
    track_d    = (state_d == ST_TRACK);
    kp_d       = track_d ? kp_trk_d : kp_acq_d;
    ki_d       = track_d ? ki_trk_d : ki_acq_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      ld_cnt   <= '0;
      lk_cnt   <= '0;
      kp_acq   <= W'(RST_KP_ACQ);
      ki_acq   <= W'(RST_KI_ACQ);
      kp_trk   <= W'(RST_KP_TRK);
      ki_trk   <= W'(RST_KI_TRK);
      kp       <= W'(RST_KP_ACQ);
      ki       <= W'(RST_KI_ACQ);
      loop_rst <= 1'b1;
      gear     <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_d;
      ld_cnt   <= ld_cnt_d;
      lk_cnt   <= lk_cnt_d;
      kp_acq   <= kp_acq_d;
      ki_acq   <= ki_acq_d;
      kp_trk   <= kp_trk_d;
      ki_trk   <= ki_trk_d;
      kp       <= kp_d;
      ki       <= ki_d;
      loop_rst <= loop_rst_d;
      gear     <= track_d;
      locked   <= track_d;
    end
  end

endmodule

// File: tb/tb_adpll_cfg_ctrl.sv
// Self-checking bench for adpll_cfg_ctrl: reset vector table, directed
// scenarios and randomized traffic against a behavioural reference model.
module tb_adpll_cfg_ctrl;

  localparam int unsigned W  = 5;
  localparam int unsigned SS = 2;
  localparam int unsigned LC = 4;
  localparam int unsigned UC = 4;
  localparam int          MAXV = (1 << W) - 1;
  localparam int          M_LOAD = 0, M_ACQ = 1, M_TRK = 2;

  logic         clk = 1'b0, rst = 1'b0, pgm = 1'b0, clr = 1'b0, upd_tick = 1'b0;
  logic [2:0]   param_sel = '0;
  logic [W-1:0] pgm_value = '0, err_mag = '0;
  logic [W-1:0] kp, ki, div_n, dco_init;
  logic         loop_rst, gear, locked;

  always #10 clk = ~clk;

  adpll_cfg_ctrl #(
    .W(W), .SYNC_STAGES(SS), .LOAD_CYCLES(LC), .UNLOCK_CNT(UC)
  ) dut (
    .clk(clk), .rst(rst), .pgm(pgm), .clr(clr), .param_sel(param_sel),
    .pgm_value(pgm_value), .upd_tick(upd_tick), .err_mag(err_mag),
    .kp(kp), .ki(ki), .div_n(div_n), .dco_init(dco_init),
    .loop_rst(loop_rst), .gear(gear), .locked(locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_reg [8];
  int m_act [4];
  int m_mode, m_left, m_cnt;
  int ph [SS+3];
  int ch [SS+3];

  function automatic int dflt(input int i);
    int v [8] = '{8, 4, 4, 1, 16, 16, 2, 16};
    return v[i];
  endfunction

  task automatic model_defaults();
    for (int i = 0; i < 8; i++) m_reg[i] = dflt(i);
    for (int i = 0; i < 4; i++) m_act[i] = dflt(i);
    m_mode = M_LOAD;
    m_left = LC;
    m_cnt  = 0;
  endtask

  // Pin samples are kept per edge; a write or clear acts SS+1 edges after
  // the pin is first seen high.
  task automatic model_edge();
    int wr, cl, win, lc, sel, val, err;
    for (int j = SS + 2; j > 0; j--) begin
      ph[j] = ph[j-1];
      ch[j] = ch[j-1];
    end
    ph[0] = int'(pgm);
    ch[0] = int'(clr);
    if (rst) begin
      for (int j = 0; j < SS + 3; j++) begin ph[j] = 0; ch[j] = 0; end
      model_defaults();
      return;
    end
    wr = (ph[SS+1] != 0) && (ph[SS+2] == 0);
    cl = ch[SS+1];
    if (cl != 0) begin
      model_defaults();
      return;
    end
    win = m_reg[6];
    lc  = (m_reg[7] == 0) ? 1 : m_reg[7];
    sel = int'(param_sel);
    val = int'(pgm_value);
    err = int'(err_mag);
    if (upd_tick) for (int i = 0; i < 4; i++) m_act[i] = m_reg[i];
    if (wr != 0 && (sel == 4 || sel == 5)) begin
      m_mode = M_LOAD; m_left = LC; m_cnt = 0;
    end else if (m_mode == M_LOAD) begin
      m_left--;
      if (m_left == 0) begin m_mode = M_ACQ; m_cnt = 0; end
    end else if (upd_tick) begin
      if (m_mode == M_ACQ) begin
        if (err <= win) begin
          if (m_cnt < MAXV) m_cnt++;
          if (m_cnt >= lc) begin m_mode = M_TRK; m_cnt = 0; end
        end else m_cnt = 0;
      end else begin
        if (err > win) begin
          if (m_cnt < MAXV) m_cnt++;
          if (m_cnt >= UC) begin m_mode = M_ACQ; m_cnt = 0; end
        end else m_cnt = 0;
      end
    end
    if (wr != 0) m_reg[sel] = val;
  endtask

  task automatic compare_model();
    chk("m_loop_rst", int'(loop_rst), int'(m_mode == M_LOAD));
    chk("m_gear",     int'(gear),     int'(m_mode == M_TRK));
    chk("m_locked",   int'(locked),   int'(m_mode == M_TRK));
    chk("m_kp",       int'(kp),       (m_mode == M_TRK) ? m_act[2] : m_act[0]);
    chk("m_ki",       int'(ki),       (m_mode == M_TRK) ? m_act[3] : m_act[1]);
    chk("m_div_n",    int'(div_n),    m_reg[4]);
    chk("m_dco_init", int'(dco_init), m_reg[5]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic tick_once(input int e);
    upd_tick = 1'b1;
    err_mag  = W'(e);
    step();
    upd_tick = 1'b0;
    step();
  endtask

  task automatic do_write(input int sel, input int val);
    param_sel = 3'(sel);
    pgm_value = W'(val);
    pgm = 1'b1;
    for (int i = 0; i < 4; i++) step();
    pgm = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic wait_load_done();
    int n = 0;
    while (loop_rst && n < 40) begin step(); n++; end
    chk("load_wait_bound", int'(loop_rst), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r; bit t; int e;
    int lr; int lk; int kp; int ki; int dn; int di;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hi, dn3, wr_timer, clr_timer;
    model_defaults();
    for (int j = 0; j < SS + 3; j++) begin ph[j] = 0; ch[j] = 0; end

    vt[0] = '{1'b1, 1'b0, 0,  1, 0, 8, 4, 16, 16};
    vt[1] = '{1'b0, 1'b0, 0,  1, 0, 8, 4, 16, 16};
    vt[2] = '{1'b0, 1'b0, 0,  1, 0, 8, 4, 16, 16};
    vt[3] = '{1'b0, 1'b0, 0,  1, 0, 8, 4, 16, 16};
    vt[4] = '{1'b0, 1'b0, 0,  0, 0, 8, 4, 16, 16};
    vt[5] = '{1'b0, 1'b1, 1,  0, 0, 8, 4, 16, 16};
    vt[6] = '{1'b0, 1'b1, 31, 0, 0, 8, 4, 16, 16};
    vt[7] = '{1'b0, 1'b0, 0,  0, 0, 8, 4, 16, 16};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rst      = vt[i].r;
      upd_tick = vt[i].t;
      err_mag  = W'(vt[i].e);
      step();
      chk("vec_loop_rst", int'(loop_rst), vt[i].lr);
      chk("vec_gear",     int'(gear),     vt[i].lk);
      chk("vec_locked",   int'(locked),   vt[i].lk);
      chk("vec_kp",       int'(kp),       vt[i].kp);
      chk("vec_ki",       int'(ki),       vt[i].ki);
      chk("vec_div_n",    int'(div_n),    vt[i].dn);
      chk("vec_dco_init", int'(dco_init), vt[i].di);
    end
    rst = 1'b0; upd_tick = 1'b0;

    // Acquisition: lock one cycle after the 16th in-window tick.
    for (int i = 1; i <= 20; i++) begin
      upd_tick = 1'b1; err_mag = W'(1);
      step();
      if (i == 15) begin
        chk("acq_locked_before", int'(locked), 0);
        chk("acq_kp_before", int'(kp), 8);
      end
      if (i == 16) begin
        chk("acq_locked_at16", int'(locked), 1);
        chk("acq_gear_at16", int'(gear), 1);
        chk("acq_kp_trk", int'(kp), 4);
        chk("acq_ki_trk", int'(ki), 1);
      end
      upd_tick = 1'b0;
      step();
    end

    // Unlock hysteresis.
    for (int i = 0; i < 3; i++) tick_once(5);
    tick_once(0);
    chk("trk_hold_locked", int'(locked), 1);
    for (int i = 1; i <= 4; i++) begin
      tick_once(5);
      if (i == 3) chk("trk_still_locked", int'(locked), 1);
    end
    chk("unlock_locked", int'(locked), 0);
    chk("unlock_gear", int'(gear), 0);
    chk("unlock_kp", int'(kp), 8);
    for (int i = 0; i < 16; i++) tick_once(0);
    chk("relock", int'(locked), 1);

    // Shadow gain write reaches kp only on the next tick.
    do_write(2, 7);
    chk("shadow_kp_held", int'(kp), 4);
    tick_once(0);
    chk("shadow_kp_applied", int'(kp), 7);

    // Divider write forces a LOAD pulse.
    param_sel = 3'd4; pgm_value = W'(10); pgm = 1'b1;
    hi = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 4) pgm = 1'b0;
      if (loop_rst) hi++;
      if (j == 3) begin
        chk("divw_pre_loop_rst", int'(loop_rst), 0);
        chk("divw_pre_locked", int'(locked), 1);
        chk("divw_pre_div_n", int'(div_n), 16);
      end
      if (j == 4) begin
        chk("divw_loop_rst", int'(loop_rst), 1);
        chk("divw_locked", int'(locked), 0);
        chk("divw_div_n", int'(div_n), 10);
      end
    end
    chk("divw_load_len", hi, LC);

    // Clear coinciding with a write: write discarded, defaults restored.
    param_sel = 3'd4; pgm_value = W'(3); pgm = 1'b1; clr = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j == 4) pgm = 1'b0;
    end
    dn3 = int'(div_n);
    chk("clr_div_n", dn3, 16);
    chk("clr_dco_init", int'(dco_init), 16);
    chk("clr_kp", int'(kp), 8);
    chk("clr_loop_rst", int'(loop_rst), 1);
    clr = 1'b0;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (loop_rst) cnt++;
    end
    chk("clr_release_load", cnt, SS + LC);
    chk("clr_write_discarded", int'(div_n), 16);

    // lock_cnt of 0 locks on the first in-window tick.
    do_write(7, 0);
    do_write(5, 9);
    wait_load_done();
    chk("lc0_dco_init", int'(dco_init), 9);
    chk("lc0_pre_locked", int'(locked), 0);
    upd_tick = 1'b1; err_mag = '0;
    step();
    upd_tick = 1'b0;
    chk("lc0_locked", int'(locked), 1);
    step();

    // Randomized traffic against the model.
    wr_timer = 0;
    clr_timer = 0;
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      upd_tick = ($urandom_range(0, 2) == 0);
      err_mag  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 31))
                                             : W'($urandom_range(0, 3));
      if (wr_timer == 0 && $urandom_range(0, 9) == 0) begin
        param_sel = 3'($urandom_range(0, 7));
        pgm_value = W'($urandom_range(0, 31));
        pgm = 1'b1;
        wr_timer = 8;
      end else if (wr_timer > 0) begin
        wr_timer--;
        if (wr_timer == 4) pgm = 1'b0;
      end
      if (clr_timer == 0 && $urandom_range(0, 79) == 0) clr_timer = $urandom_range(1, 6);
      clr = (clr_timer > 0);
      if (clr_timer > 0) clr_timer--;
      step();
    end
    rst = 1'b0; pgm = 1'b0; clr = 1'b0; upd_tick = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
